// File: rtl/cv32e40p_apu_disp_tracker_pkg.sv
// Shared APU core widths and the dispatcher's request/writeback payload types.
package cv32e40p_apu_disp_tracker_pkg;

    localparam int APU_NARGS_CPU       = 3;
    localparam int APU_WOP_CPU         = 6;
    localparam int APU_NDSFLAGS_CPU    = 15;
    localparam int APU_NUSFLAGS_CPU    = 5;
    localparam int APU_MAX_OUTSTANDING = 2;

    // Number of ID-stage source addresses checked for RAW hazards.
    localparam int NUM_CHK = 3;

    typedef struct packed {
        logic [APU_WOP_CPU-1:0]        op;
        logic [APU_NARGS_CPU*32-1:0]   operands;
        logic [APU_NDSFLAGS_CPU-1:0]   flags;
    } apu_req_t;

    typedef struct packed {
        logic [31:0]                   result;
        logic [APU_NUSFLAGS_CPU-1:0]   flags;
    } apu_wb_t;

endpackage

// File: rtl/cv32e40p_apu_tag_fifo.sv
// In-order destination-tag FIFO for granted APU operations; entries and a
// per-slot valid vector are exposed for the hazard compare.
module cv32e40p_apu_tag_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 6,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W-1:0]             push_tag,
    input  logic                          pop,
    output logic [ADDR_W-1:0]             head_tag,
    output logic [CNT_W-1:0]              count,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entries,
    output logic [DEPTH-1:0]              entry_vld
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] mem;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem       <= '0;
            entry_vld <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            // Pop clears before push sets, so a shared slot ends up valid.
            if (pop) begin
                entry_vld[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr]       <= push_tag;
                entry_vld[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_tag = mem[rd_ptr];
    assign entries  = mem;

endmodule

// File: rtl/cv32e40p_apu_disp_tracker.sv
// Dispatches issued APU operations over the req/gnt handshake, tracks
// outstanding destination tags and produces a registered writeback.
module cv32e40p_apu_disp_tracker
    import cv32e40p_apu_disp_tracker_pkg::*;
#(
    parameter int DEPTH  = APU_MAX_OUTSTANDING,
    parameter int ADDR_W = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [APU_WOP_CPU-1:0]        issue_op_i,
    input  logic [APU_NARGS_CPU*32-1:0]   issue_operands_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]   issue_flags_i,
    input  logic [ADDR_W-1:0]             issue_waddr_i,
    output logic                          apu_req_o,
    input  logic                          apu_gnt_i,
    output logic [APU_WOP_CPU-1:0]        apu_op_o,
    output logic [APU_NARGS_CPU*32-1:0]   apu_operands_o,
    output logic [APU_NDSFLAGS_CPU-1:0]   apu_flags_o,
    input  logic                          apu_rvalid_i,
    input  logic [31:0]                   apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]   apu_rflags_i,
    output logic                          wb_valid_o,
    output logic [ADDR_W-1:0]             wb_waddr_o,
    output logic [31:0]                   wb_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]   wb_flags_o,
    input  logic [NUM_CHK*ADDR_W-1:0]     chk_raddr_i,
    output logic                          hazard_o,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                         req_pend;
    apu_req_t                     req_q;
    logic [ADDR_W-1:0]            waddr_q;
    apu_wb_t                      wb_q;
    logic                         accept;
    logic                         grant;
    logic                         pop;
    logic                         fifo_empty;
    logic [ADDR_W-1:0]            head_tag;
    logic [CNT_W-1:0]             count;
    logic [DEPTH-1:0][ADDR_W-1:0] entries;
    logic [DEPTH-1:0]             entry_vld;

    // Gated by rst so every output reads 0 while reset is held.
    assign issue_ready_o = !rst && !req_pend && (count < CNT_W'(DEPTH));
    assign accept        = issue_valid_i && issue_ready_o;
    assign grant         = req_pend && apu_gnt_i;
    assign fifo_empty    = (count == '0);
    assign pop           = apu_rvalid_i && !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pend <= 1'b0;
            req_q    <= '0;
            waddr_q  <= '0;
        end else if (accept) begin
            req_pend       <= 1'b1;
            req_q.op       <= issue_op_i;
            req_q.operands <= issue_operands_i;
            req_q.flags    <= issue_flags_i;
            waddr_q        <= issue_waddr_i;
        end else if (grant) begin
            req_pend <= 1'b0;
        end
    end

    assign apu_req_o      = req_pend;
    assign apu_op_o       = req_q.op;
    assign apu_operands_o = req_q.operands;
    assign apu_flags_o    = req_q.flags;

    cv32e40p_apu_tag_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_tag  (waddr_q),
        .pop       (pop),
        .head_tag  (head_tag),
        .count     (count),
        .entries   (entries),
        .entry_vld (entry_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            wb_waddr_o <= '0;
            wb_q       <= '0;
        end else begin
            wb_valid_o <= pop;
            if (pop) begin
                wb_waddr_o  <= head_tag;
                wb_q.result <= apu_result_i;
                wb_q.flags  <= apu_rflags_i;
            end
        end
    end

    assign wb_result_o = wb_q.result;
    assign wb_flags_o  = wb_q.flags;

    // A response with no outstanding tag is dropped and flagged until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (apu_rvalid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < NUM_CHK; i++) begin
            if (chk_raddr_i[i*ADDR_W +: ADDR_W] != '0) begin
                if (req_pend && chk_raddr_i[i*ADDR_W +: ADDR_W] == waddr_q)
                    hazard_o = 1'b1;
                if (wb_valid_o && chk_raddr_i[i*ADDR_W +: ADDR_W] == wb_waddr_o)
                    hazard_o = 1'b1;
                for (int j = 0; j < DEPTH; j++) begin
                    if (entry_vld[j] && chk_raddr_i[i*ADDR_W +: ADDR_W] == entries[j])
                        hazard_o = 1'b1;
                end
            end
        end
    end

    assign busy_o = req_pend || !fifo_empty;

endmodule

// File: tb/tb_cv32e40p_apu_disp_tracker.sv
// Directed bench for the APU dispatcher: queue-based reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_cv32e40p_apu_disp_tracker;
    import cv32e40p_apu_disp_tracker_pkg::*;

    localparam int DEPTH  = 2;
    localparam int ADDR_W = 6;
    localparam int OPW    = APU_NARGS_CPU * 32;

    logic                         clk;
    logic                         rst;
    logic                         issue_valid_i;
    logic                         issue_ready_o;
    logic [APU_WOP_CPU-1:0]       issue_op_i;
    logic [OPW-1:0]               issue_operands_i;
    logic [APU_NDSFLAGS_CPU-1:0]  issue_flags_i;
    logic [ADDR_W-1:0]            issue_waddr_i;
    logic                         apu_req_o;
    logic                         apu_gnt_i;
    logic [APU_WOP_CPU-1:0]       apu_op_o;
    logic [OPW-1:0]               apu_operands_o;
    logic [APU_NDSFLAGS_CPU-1:0]  apu_flags_o;
    logic                         apu_rvalid_i;
    logic [31:0]                  apu_result_i;
    logic [APU_NUSFLAGS_CPU-1:0]  apu_rflags_i;
    logic                         wb_valid_o;
    logic [ADDR_W-1:0]            wb_waddr_o;
    logic [31:0]                  wb_result_o;
    logic [APU_NUSFLAGS_CPU-1:0]  wb_flags_o;
    logic [3*ADDR_W-1:0]          chk_raddr_i;
    logic                         hazard_o;
    logic                         busy_o;
    logic                         err_o;

    int n_vec = 0;
    int n_err = 0;

    cv32e40p_apu_disp_tracker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .issue_op_i       (issue_op_i),
        .issue_operands_i (issue_operands_i),
        .issue_flags_i    (issue_flags_i),
        .issue_waddr_i    (issue_waddr_i),
        .apu_req_o        (apu_req_o),
        .apu_gnt_i        (apu_gnt_i),
        .apu_op_o         (apu_op_o),
        .apu_operands_o   (apu_operands_o),
        .apu_flags_o      (apu_flags_o),
        .apu_rvalid_i     (apu_rvalid_i),
        .apu_result_i     (apu_result_i),
        .apu_rflags_i     (apu_rflags_i),
        .wb_valid_o       (wb_valid_o),
        .wb_waddr_o       (wb_waddr_o),
        .wb_result_o      (wb_result_o),
        .wb_flags_o       (wb_flags_o),
        .chk_raddr_i      (chk_raddr_i),
        .hazard_o         (hazard_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pending slot, a queue of outstanding tags, a wb record.
    bit                           m_pend;
    logic [APU_WOP_CPU-1:0]       m_op;
    logic [OPW-1:0]               m_opnds;
    logic [APU_NDSFLAGS_CPU-1:0]  m_flags;
    logic [ADDR_W-1:0]            m_waddr;
    logic [ADDR_W-1:0]            m_q[$];
    bit                           m_wbv;
    logic [ADDR_W-1:0]            m_wba;
    logic [31:0]                  m_wbr;
    logic [APU_NUSFLAGS_CPU-1:0]  m_wbf;
    bit                           m_err;
    bit                           m_acc;
    bit                           m_gnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_wbv = 0; m_err = 0;
            m_q.delete();
        end else begin
            m_acc = issue_valid_i && !m_pend && (m_q.size() < DEPTH);
            m_gnt = m_pend && apu_gnt_i;
            m_wbv = 0;
            if (apu_rvalid_i) begin
                if (m_q.size() == 0) m_err = 1;
                else begin
                    m_wbv = 1;
                    m_wba = m_q.pop_front();
                    m_wbr = apu_result_i;
                    m_wbf = apu_rflags_i;
                end
            end
            if (m_gnt) begin
                m_q.push_back(m_waddr);
                m_pend = 0;
            end
            if (m_acc) begin
                m_pend  = 1;
                m_op    = issue_op_i;
                m_opnds = issue_operands_i;
                m_flags = issue_flags_i;
                m_waddr = issue_waddr_i;
            end
        end
    end

    function automatic bit model_hazard();
        bit h = 0;
        for (int i = 0; i < 3; i++) begin
            logic [ADDR_W-1:0] a = chk_raddr_i[i*ADDR_W +: ADDR_W];
            if (a != 0) begin
                if (m_pend && a == m_waddr) h = 1;
                if (m_wbv && a == m_wba) h = 1;
                foreach (m_q[k]) if (m_q[k] == a) h = 1;
            end
        end
        return h;
    endfunction

    always @(negedge clk) begin
        chk("issue_ready", issue_ready_o, !rst && !m_pend && (m_q.size() < DEPTH));
        chk("apu_req", apu_req_o, m_pend);
        if (m_pend) begin
            chk("apu_op", apu_op_o, m_op);
            chk("apu_operands", apu_operands_o, m_opnds);
            chk("apu_flags", apu_flags_o, m_flags);
        end
        chk("wb_valid", wb_valid_o, m_wbv);
        if (m_wbv) begin
            chk("wb_waddr", wb_waddr_o, m_wba);
            chk("wb_result", wb_result_o, m_wbr);
            chk("wb_flags", wb_flags_o, m_wbf);
        end
        chk("busy", busy_o, m_pend || m_q.size() != 0);
        chk("err", err_o, m_err);
        chk("hazard", hazard_o, model_hazard());
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [APU_WOP_CPU-1:0] op, input logic [OPW-1:0] opnds,
                         input logic [APU_NDSFLAGS_CPU-1:0] fl, input logic [ADDR_W-1:0] wa);
        issue_valid_i    = 1'b1;
        issue_op_i       = op;
        issue_operands_i = opnds;
        issue_flags_i    = fl;
        issue_waddr_i    = wa;
    endtask

    task automatic respond(input logic [31:0] res, input logic [APU_NUSFLAGS_CPU-1:0] fl);
        apu_rvalid_i = 1'b1;
        apu_result_i = res;
        apu_rflags_i = fl;
    endtask

    initial begin
        rst = 1'b1;
        issue_valid_i = 0; issue_op_i = '0; issue_operands_i = '0; issue_flags_i = '0;
        issue_waddr_i = '0; apu_gnt_i = 0; apu_rvalid_i = 0; apu_result_i = '0;
        apu_rflags_i = '0; chk_raddr_i = '0;

        // Reset state
        step(2);
        @(negedge clk);
        chk("rst_req", apu_req_o, 1'b0);
        chk("rst_ready", issue_ready_o, 1'b0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_operands", apu_operands_o, '0);
        @(posedge clk); #1 rst = 1'b0;

        // Single op, waddr 5
        apu_gnt_i = 1;
        issue(6'h0a, 96'h0123_4567_89ab_cdef_0011_2233, 15'h1234, 6'd5);
        step();
        issue_valid_i = 0;
        @(negedge clk);
        chk("t1_req_after_accept", apu_req_o, 1'b1);
        chk("t1_op", apu_op_o, 6'h0a);
        step();
        apu_gnt_i = 0;
        step();
        respond(32'h3F80_0000, 5'h03);
        step();
        apu_rvalid_i = 0;
        @(negedge clk);
        chk("t1_wb_valid", wb_valid_o, 1'b1);
        chk("t1_wb_waddr", wb_waddr_o, 6'd5);
        chk("t1_wb_result", wb_result_o, 32'h3F80_0000);
        step();
        @(negedge clk);
        chk("t1_wb_pulse", wb_valid_o, 1'b0);
        chk("t1_idle", busy_o, 1'b0);

        // Grant stall: a competing offer must not disturb the held request
        issue(6'h15, 96'hA5A5_A5A5_5A5A_5A5A_F00D_BEEF, 15'h0F0F, 6'd6);
        step();
        issue(6'h2a, 96'h1111_2222_3333_4444_5555_6666, 15'h7777, 6'd8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_req_held", apu_req_o, 1'b1);
            chk("t2_operands_held", apu_operands_o, 96'hA5A5_A5A5_5A5A_5A5A_F00D_BEEF);
            chk("t2_ready", issue_ready_o, 1'b0);
            chk("t2_busy", busy_o, 1'b1);
            step();
        end
        issue_valid_i = 0;
        apu_gnt_i = 1;
        step();
        apu_gnt_i = 0;
        respond(32'hDEAD_0006, 5'h01);
        step();
        apu_rvalid_i = 0;
        step();

        // Fill: 7 then 9 outstanding, responses in order
        apu_gnt_i = 1;
        issue(6'h01, 96'h7, 15'h1, 6'd7);
        step();
        issue_valid_i = 0;
        step();
        issue(6'h02, 96'h9, 15'h2, 6'd9);
        step();
        issue_valid_i = 0;
        step();
        apu_gnt_i = 0;
        @(negedge clk);
        chk("t3_full_ready", issue_ready_o, 1'b0);
        chk("t3_full_busy", busy_o, 1'b1);
        issue(6'h03, 96'hd, 15'h3, 6'd13);
        step();
        issue_valid_i = 0;
        respond(32'h0000_0011, 5'h11);
        step();
        apu_rvalid_i = 0;
        @(negedge clk);
        chk("t3_first_wb", wb_waddr_o, 6'd7);
        chk("t3_first_res", wb_result_o, 32'h11);
        respond(32'h0000_0022, 5'h12);
        step();
        apu_rvalid_i = 0;
        @(negedge clk);
        chk("t3_second_wb", wb_waddr_o, 6'd9);
        chk("t3_second_res", wb_result_o, 32'h22);
        step();

        // Simultaneous grant of 11 and response for 7
        apu_gnt_i = 1;
        issue(6'h04, 96'h7, 15'h4, 6'd7);
        step();
        issue_valid_i = 0;
        step();
        issue(6'h05, 96'hb, 15'h5, 6'd11);
        step();
        issue_valid_i = 0;
        respond(32'h0000_0033, 5'h13);
        step();
        apu_rvalid_i = 0;
        apu_gnt_i = 0;
        @(negedge clk);
        chk("t4_wb_valid", wb_valid_o, 1'b1);
        chk("t4_wb_waddr", wb_waddr_o, 6'd7);
        chk("t4_busy_11_left", busy_o, 1'b1);
        respond(32'h0000_0044, 5'h14);
        step();
        apu_rvalid_i = 0;
        @(negedge clk);
        chk("t4_wb_11", wb_waddr_o, 6'd11);
        step();
        @(negedge clk);
        chk("t4_drained", busy_o, 1'b0);

        // Hazard on waddr 12 through pending, FIFO and wb phases
        chk_raddr_i = {6'd0, 6'd12, 6'd3};
        issue(6'h06, 96'hc, 15'h6, 6'd12);
        step();
        issue_valid_i = 0;
        @(negedge clk);
        chk("t5_haz_pending", hazard_o, 1'b1);
        apu_gnt_i = 1;
        step();
        apu_gnt_i = 0;
        @(negedge clk);
        chk("t5_haz_fifo", hazard_o, 1'b1);
        respond(32'h0000_0055, 5'h15);
        step();
        apu_rvalid_i = 0;
        @(negedge clk);
        chk("t5_haz_wb", hazard_o, 1'b1);
        step();
        @(negedge clk);
        chk("t5_haz_cleared", hazard_o, 1'b0);
        chk_raddr_i = '0;
        issue(6'h07, 96'h0, 15'h7, 6'd0);
        step();
        issue_valid_i = 0;
        @(negedge clk);
        chk("t5_zero_no_haz", hazard_o, 1'b0);
        apu_gnt_i = 1;
        step();
        apu_gnt_i = 0;
        respond(32'h0000_0066, 5'h16);
        step();
        apu_rvalid_i = 0;
        step();

        // Response with empty FIFO, then grant into empty FIFO with same-cycle response
        respond(32'hBAD0_0001, 5'h1f);
        step();
        apu_rvalid_i = 0;
        @(negedge clk);
        chk("t6_err", err_o, 1'b1);
        chk("t6_no_wb", wb_valid_o, 1'b0);
        apu_gnt_i = 1;
        issue(6'h08, 96'h14, 15'h8, 6'd20);
        step();
        issue_valid_i = 0;
        respond(32'hBAD0_0002, 5'h1e);
        step();
        apu_rvalid_i = 0;
        apu_gnt_i = 0;
        @(negedge clk);
        chk("t6_same_cycle_dropped", wb_valid_o, 1'b0);
        chk("t6_tag_kept", busy_o, 1'b1);

        // Reset mid-request
        chk_raddr_i = {6'd21, 6'd20, 6'd0};
        issue(6'h09, 96'h15, 15'h9, 6'd21);
        step();
        issue_valid_i = 0;
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_req", apu_req_o, 1'b0);
        chk("t7_rst_busy", busy_o, 1'b0);
        chk("t7_rst_err", err_o, 1'b0);
        chk("t7_rst_ready", issue_ready_o, 1'b0);
        chk("t7_rst_hazard", hazard_o, 1'b0);
        chk("t7_rst_op", apu_op_o, '0);
        @(posedge clk); #1 rst = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cv32e40p_apu_disp_tracker.md
Name: cv32e40p_apu_disp_tracker

Overview:
- Core-side dispatcher between the EX-stage issue logic and the shared APU interface.
- Registers an issued APU operation and drives the APU req/gnt handshake.
- Tracks in-order outstanding operations in a small tag FIFO and matches each APU response to its destination register.
- Produces a registered writeback, plus a RAW-hazard indication for the ID stage.

Parameters:
- DEPTH, 2, max outstanding granted-but-unanswered operations (power of two, ≥2).
- ADDR_W, 6, destination register address width (GPR + FP space).
- APU_NARGS_CPU / APU_WOP_CPU / APU_NDSFLAGS_CPU / APU_NUSFLAGS_CPU, taken from the shared APU core package (3/6/15/5).

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid_i  in  1  EX offers an APU operation
- issue_ready_o  out  1  dispatcher accepts operation this cycle
- issue_op_i  in  APU_WOP_CPU  operation code
- issue_operands_i  in  APU_NARGS_CPU*32  packed operands
- issue_flags_i  in  APU_NDSFLAGS_CPU  downstream flags
- issue_waddr_i  in  ADDR_W  destination register
- apu_req_o  out  1  request to APU
- apu_gnt_i  in  1  APU grant
- apu_op_o  out  APU_WOP_CPU  registered op
- apu_operands_o  out  APU_NARGS_CPU*32  registered operands
- apu_flags_o  out  APU_NDSFLAGS_CPU  registered flags
- apu_rvalid_i  in  1  APU result valid
- apu_result_i  in  32  APU result
- apu_rflags_i  in  APU_NUSFLAGS_CPU  upstream flags
- wb_valid_o  out  1  writeback strobe
- wb_waddr_o  out  ADDR_W  writeback address
- wb_result_o  out  32  writeback data
- wb_flags_o  out  APU_NUSFLAGS_CPU  writeback flags
- chk_raddr_i  in  3*ADDR_W  ID source addresses to check
- hazard_o  out  1  any source matches an in-flight destination
- busy_o  out  1  request pending or FIFO non-empty
- err_o  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0; request register, FIFO pointers/count, wb register and err cleared. Reset mid-operation discards the pending request and all tags.
- issue_ready_o = !req_pend && (count < DEPTH). This is combinational from state only, never from issue_valid_i.
- Accept (issue_valid_i && issue_ready_o):
  - Next cycle: req_pend=1, apu_req_o=1, apu_op/operands/flags/waddr latched.
  - Issue-to-req latency is exactly 1 cycle.
- While apu_req_o=1 and apu_gnt_i=0: all apu_* outputs are held stable.
- Grant (apu_req_o && apu_gnt_i):
  - Push waddr into the FIFO; req_pend clears next cycle.
  - Back-to-back issue is allowed only after the grant cycle, because ready depends on req_pend. Maximum throughput is 1 op / 2 cycles.
- Response (apu_rvalid_i):
  - Pop the oldest tag.
  - Next cycle: wb_valid_o=1, with wb_waddr_o = popped tag, wb_result_o = apu_result_i, wb_flags_o = apu_rflags_i.
  - Response-to-writeback latency is exactly 1 cycle. wb_valid_o is a single-cycle pulse per response.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance (wrap modulo DEPTH).
- apu_rvalid_i with the FIFO empty (including same-cycle grant into an empty FIFO): the response is dropped, no wb, err_o set until reset.
- hazard_o (combinational): any chk_raddr_i field ≠ 0 equals any of:
  - the pending request waddr (req_pend), or
  - a valid FIFO entry, or
  - wb_waddr_o while wb_valid_o.
- busy_o = req_pend || count ≠ 0.

Decomposition:
- Shared APU core package: holds the NARGS/WOP/flag widths and a new constant APU_MAX_OUTSTANDING = 2 (the DEPTH default).
- One sub-module: cv32e40p_apu_tag_fifo.
  - DEPTH × ADDR_W register array with rd/wr pointers and count.
  - Exposes the entries plus a valid vector for the hazard compare.

Test Plan:
- Single op: issue waddr=5, gnt on the first req cycle, rvalid 2 cycles later with result 0x3F800000 → apu_req_o high 1 cycle after accept; wb_valid_o 1 cycle after rvalid with waddr=5, result 0x3F800000.
- Gnt stall: hold apu_gnt_i=0 for 4 cycles → apu_req_o and operands stable all 4 cycles, issue_ready_o=0, busy_o=1.
- Fill: two ops waddr=7, then 9, granted with no responses → count=2, issue_ready_o=0. The responses then write back in order, 7 then 9.
- Simultaneous: grant of op waddr=11 in the same cycle as rvalid for waddr=7 → count unchanged; wb for 7; 11 stays in the FIFO.
- Hazard: waddr=12 in flight, chk_raddr_i={0,12,3} → hazard_o=1. After its wb cycle ends → hazard_o=0. A chk of address 0 never hazards.
- Error/reset: rvalid with an empty FIFO → no wb, err_o=1. Assert rst mid-request → all outputs 0, err_o cleared.
